ws2812_multi: RTL and testbench
===============================

# ws2812_multi

Parametrised multi-channel WS2812 serial LED driver, successor to the single-strip `ws2812` used by the top level. Streams a frame of `PIXELS` 24-bit GRB words per channel, for `CHANNELS` strips in lockstep. Pixel data is pulled from an external synchronous frame store (e.g. the physics matrix rendered to RAM) through an address/data port. Bit timing and the latch gap are parameters, so the same RTL serves 12 MHz and PLL-derived clocks.

## Interface
- `CHANNELS`, 1: number of parallel strips (1–8).
- `PIXELS`, 256: pixels per strip (16×16 matrix).
- `T_BIT`, 15: clock cycles per data bit (1.25 µs at 12 MHz).
- `T0H`, 5: high cycles for a 0 bit.
- `T1H`, 10: high cycles for a 1 bit.
- `T_RESET`, 3600: low cycles of the latch gap (300 µs at 12 MHz).
- Legal parameter range: 1 ≤ `T0H` < `T1H` < `T_BIT`, `T_BIT` ≥ 2, `PIXELS` ≥ 1.

Ports:
- `clk` in 1: single clock domain.
- `reset` in 1: synchronous, active-high.
- `start` in 1: frame request, sampled in IDLE only.
- `pix_addr` out `AW` = max(1, $clog2(`PIXELS`)): pixel index being fetched.
- `pix_data` in `CHANNELS`*24: `{ch[N-1] … ch[0]}`, each `{G[7:0],R[7:0],B[7:0]}`. Must be valid one cycle after `pix_addr`.
- `o_out` out `CHANNELS`: serial data line per strip.
- `busy` out 1: high from the first FETCH cycle through the last LATCH cycle.
- `frame_done` out 1: one-cycle pulse after the latch gap completes.

## Operation
- FSM states: IDLE, FETCH, SEND, LATCH.
- **IDLE:** `o_out`=0, `busy`=0. `start`=1 moves to FETCH.
- **FETCH:** 2 cycles.
  - Cycle 1 drives `pix_addr`=0.
  - Cycle 2 registers `pix_data` into per-channel 24-bit shift registers.
  - Then enters SEND.
- **SEND:** bits go out MSB first (G7 first). Each bit occupies `T_BIT` cycles: `o_out[c]`=1 for `T1H` (bit=1) or `T0H` (bit=0) cycles, then 0 for the remainder. All channels share the bit counter; only data differs.
- **Prefetch:** during the first cycle of bit 23 (the last bit) of pixel p < `PIXELS`−1, `pix_addr` becomes p+1. `pix_data` is captured on the last cycle of that bit. The next pixel's bit 0 starts on the following cycle, with no inter-pixel gap.
- After the last bit of pixel `PIXELS`−1, the FSM enters LATCH. `pix_addr` holds `PIXELS`−1.
- **LATCH:** `o_out`=0 for `T_RESET` cycles. It then returns to IDLE, and `frame_done` pulses in the first IDLE cycle.
- **Counters:**
  - Cycle-in-bit counter: $clog2(`T_BIT`) bits.
  - Bit counter: 0..23.
  - Pixel counter: `AW` bits.
  - Latch counter: $clog2(`T_RESET`+1) bits.
  - No counter wraps in normal operation; each is cleared on state entry.
- **Boundaries:**
  - `start` while `busy` is ignored, not queued.
  - `start` held high re-triggers only from IDLE. `frame_done` and the next FETCH may coincide in the same cycle.
  - `PIXELS`=1 skips the prefetch and goes straight to LATCH after bit 23.
  - `pix_data` changes outside the capture cycle have no effect.

## Timing
- Reset values: `o_out`=0, `busy`=0, `frame_done`=0, `pix_addr`=0, state=IDLE.
- Reset mid-frame takes effect on the next edge: all outputs return to reset values and no `frame_done` is emitted.
- Latency: `start` high at edge k, so `busy`=1 from cycle k+1 and the first `o_out` rising edge occurs at cycle k+3.
- `busy` width is 2 + `PIXELS`·24·`T_BIT` + `T_RESET` cycles.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `WS2812_AUTO_REFRESH_EN` defined:
  - The FSM moves IDLE→FETCH unconditionally and `start` is ignored.
  - After LATCH it goes straight to FETCH, with one IDLE cycle in between in which `frame_done` pulses. `busy` drops for exactly that cycle.
  - Frames repeat continuously from reset release.
- Undefined: frames run only on `start`, as described in Operation.

## Test plan
All scenarios use `CHANNELS`=2, `PIXELS`=2, `T_BIT`=6, `T0H`=2, `T1H`=4, `T_RESET`=10.
- **Single frame:** pixel0 = {ch1 0x000000, ch0 0xFFFFFF}, pixel1 = {0xA5A5A5, 0x0F0F0F}, `start` pulse. Expected:
  - ch0: 24 pulses 4-high/2-low, then the 0x0F0F0F pattern.
  - ch1: 24 pulses 2-high/2… i.e. 2-high/4-low, then 0xA5A5A5.
  - `busy` high for exactly 300 cycles; `frame_done` pulses once.
- **Prefetch timing:** `pix_addr` goes 0→1 on the first cycle of bit 23 of pixel 0. Changing `pix_data` after the capture cycle does not alter the output. No gap appears between pixels.
- **start during busy:** `start` pulsed at cycle 50 of a frame is ignored. Total `busy` is still 300 and there is exactly one `frame_done`.
- **Reset mid-frame:** `reset` asserted at cycle 100. The next cycle shows `o_out`=00, `busy`=0, `pix_addr`=0, and no `frame_done`. A new `start` then produces a full, correct frame.
- **Back-to-back:** `start` held high. Frames repeat with one IDLE cycle between them; `frame_done` coincides with the next FETCH cycle 1.
- **`WS2812_AUTO_REFRESH_EN`:** with `start` tied 0, the first rising edge of `o_out` lands 3 cycles after `reset` deasserts. `frame_done` then pulses every 301 cycles.

Source files
------------

// File: rtl/ws2812_multi_if.sv
// ws2812_multi_if: frame-request handshake, frame-store fetch port and the
// per-strip serial lines of the multi-channel WS2812 driver.
// master = driver side, slave = host / frame-store side.
interface ws2812_multi_if #(
  parameter int CHANNELS = 1,
  parameter int PIXELS   = 256
);
  localparam int AW = (PIXELS > 1) ? $clog2(PIXELS) : 1;

  logic                     start;
  logic [AW-1:0]            pix_addr;
  logic [CHANNELS*24-1:0]   pix_data;
  logic [CHANNELS-1:0]      o_out;
  logic                     busy;
  logic                     frame_done;

  modport master (
    input  start, pix_data,
    output pix_addr, o_out, busy, frame_done
  );

  modport slave (
    output start, pix_data,
    input  pix_addr, o_out, busy, frame_done
  );
endinterface

// File: rtl/ws2812_multi.sv
// ws2812_multi: streams PIXELS 24-bit GRB words per strip to CHANNELS WS2812
// strips in lockstep, fetching pixels from a synchronous frame store
// (data valid one cycle after pix_addr), followed by a T_RESET latch gap.
// Optional feature macro: WS2812_AUTO_REFRESH_EN -- when defined, frames repeat
// continuously from reset release and start is ignored.
// T_RESET is expected to be at least 1.
module ws2812_multi #(
  parameter int CHANNELS = 1,
  parameter int PIXELS   = 256,
  parameter int T_BIT    = 15,
  parameter int T0H      = 5,
  parameter int T1H      = 10,
  parameter int T_RESET  = 3600
) (
  input  logic             clk,
  input  logic             reset,
  ws2812_multi_if.master   bus
);
  localparam int AW = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam int CW = $clog2(T_BIT);
  localparam int LW = $clog2(T_RESET + 1);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, LATCH} state_t;

  state_t                state_reg;
  logic [CW-1:0]         cyc_reg;
  logic [4:0]            bit_reg;
  logic [AW-1:0]         pix_reg;
  logic [LW-1:0]         lat_reg;
  logic [23:0]           shift_reg [CHANNELS];
  logic [AW-1:0]         addr_reg;
  logic [CHANNELS-1:0]   out_reg;
  logic                  busy_reg;
  logic                  done_reg;

  logic                  go;
  logic [CHANNELS-1:0]   hi_next;
  logic [23:0]           data_ch [CHANNELS];

`ifdef WS2812_AUTO_REFRESH_EN
  assign go = 1'b1;
`else
  assign go = bus.start;
`endif

  // Per-channel data slice and "still high on the next cycle of this bit" decode
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    assign data_ch[gi] = bus.pix_data[gi*24 +: 24];
    assign hi_next[gi] = (int'(cyc_reg) + 1) < (shift_reg[gi][23] ? T1H : T0H);
  end

  // Frame FSM: fetch, serialise with prefetch of the next pixel, latch gap
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cyc_reg   <= '0;
      bit_reg   <= '0;
      pix_reg   <= '0;
      lat_reg   <= '0;
      addr_reg  <= '0;
      out_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (go) begin
            state_reg <= FETCH;
            busy_reg  <= 1'b1;
            addr_reg  <= '0;
            cyc_reg   <= '0;
          end
        end
        FETCH: begin
          if (cyc_reg == '0) begin
            cyc_reg <= CW'(1);
          end else begin
            for (int c = 0; c < CHANNELS; c++) shift_reg[c] <= data_ch[c];
            state_reg <= SEND;
            cyc_reg   <= '0;
            bit_reg   <= '0;
            pix_reg   <= '0;
            out_reg   <= '1;
          end
        end
        SEND: begin
          if (cyc_reg == CW'(T_BIT - 1)) begin
            cyc_reg <= '0;
            if (bit_reg == 5'd23) begin
              if (pix_reg == AW'(PIXELS - 1)) begin
                state_reg <= LATCH;
                out_reg   <= '0;
                lat_reg   <= '0;
              end else begin
                // Next pixel was addressed at the start of bit 23; its data is valid now
                for (int c = 0; c < CHANNELS; c++) shift_reg[c] <= data_ch[c];
                pix_reg <= pix_reg + 1'b1;
                bit_reg <= '0;
                out_reg <= '1;
              end
            end else begin
              for (int c = 0; c < CHANNELS; c++) shift_reg[c] <= {shift_reg[c][22:0], 1'b0};
              bit_reg <= bit_reg + 1'b1;
              out_reg <= '1;
              if (bit_reg == 5'd22 && pix_reg != AW'(PIXELS - 1)) begin
                addr_reg <= pix_reg + 1'b1;
              end
            end
          end else begin
            cyc_reg <= cyc_reg + 1'b1;
            out_reg <= hi_next;
          end
        end
        LATCH: begin
          if (lat_reg == LW'(T_RESET - 1)) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end else begin
            lat_reg <= lat_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.pix_addr   = addr_reg;
  assign bus.o_out      = out_reg;
  assign bus.busy       = busy_reg;
  assign bus.frame_done = done_reg;
endmodule

// File: tb/tb_ws2812_multi.sv
// tb_ws2812_multi: randomized/directed stimulus for ws2812_multi, checked every
// cycle against a timeline model (frame position -> pixel/bit/phase arithmetic).
module tb_ws2812_multi;
  localparam int CH = 2;
  localparam int PX = 2;
  localparam int TB = 6;
  localparam int T0 = 2;
  localparam int T1 = 4;
  localparam int TR = 10;
  localparam int SEND_LEN = PX * 24 * TB;
  localparam int BUSY_LEN = 2 + SEND_LEN + TR;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ws2812_multi_if #(.CHANNELS(CH), .PIXELS(PX)) bus ();

  ws2812_multi #(
    .CHANNELS(CH), .PIXELS(PX), .T_BIT(TB), .T0H(T0), .T1H(T1), .T_RESET(TR)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [CH*24-1:0] mem [PX];

  int tests  = 0;
  int errors = 0;

  // model state
  int             cyc      = 0;
  bit             m_active = 1'b0;
  bit             m_fd     = 1'b0;
  int             m_t      = 0;
  int             m_addr   = 0;
  logic [CH-1:0]  exp_o    = '0;
  bit             need_data = 1'b0;
  int             cap_pix  = 0;

  // monitors
  int busy_total  = 0;
  int fd_total    = 0;
  int last_fd_cyc = -1;
  int fd_gap      = 0;

  // Reference model: where in the frame are we, and what must each line show
  always @(posedge clk) begin
    bit go_now;
    int s, p, b, c;
    cyc = cyc + 1;
`ifdef WS2812_AUTO_REFRESH_EN
    go_now = 1'b1;
`else
    go_now = (bus.start === 1'b1);
`endif
    if (reset) begin
      m_active = 1'b0;
      m_fd     = 1'b0;
      m_addr   = 0;
      m_t      = 0;
    end else begin
      m_fd = 1'b0;
      if (m_active) begin
        m_t = m_t + 1;
        if (m_t == BUSY_LEN) begin
          m_active = 1'b0;
          m_fd     = 1'b1;
        end
      end else if (go_now) begin
        m_active = 1'b1;
        m_t      = 0;
      end
    end
    exp_o     = '0;
    need_data = 1'b0;
    if (m_active) begin
      if (m_t < 2) begin
        m_addr    = 0;
        need_data = (m_t == 1);
        cap_pix   = 0;
      end else if (m_t < 2 + SEND_LEN) begin
        s = m_t - 2;
        p = s / (24 * TB);
        b = (s / TB) % 24;
        c = s % TB;
        for (int ch = 0; ch < CH; ch++) begin
          exp_o[ch] = (c < (mem[p][ch*24 + 23 - b] ? T1 : T0));
        end
        m_addr = (b == 23 && p < PX - 1) ? p + 1 : p;
        if (b == 23 && c == TB - 1 && p < PX - 1) begin
          need_data = 1'b1;
          cap_pix   = p + 1;
        end
      end else begin
        m_addr = PX - 1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests = tests + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // One cycle: compare outputs against the model, update monitors, drive pix_data
  task automatic tick();
    logic [63:0] r;
    @(negedge clk);
    chk("o_out",      int'(bus.o_out),      int'(exp_o));
    chk("busy",       int'(bus.busy),       int'(m_active));
    chk("frame_done", int'(bus.frame_done), int'(m_fd));
    chk("pix_addr",   int'(bus.pix_addr),   m_addr);
    busy_total = busy_total + int'(bus.busy);
    if (bus.frame_done === 1'b1) begin
      if (last_fd_cyc >= 0) fd_gap = cyc - last_fd_cyc;
      last_fd_cyc = cyc;
      fd_total    = fd_total + 1;
    end
    r = {$urandom(), $urandom()};
    bus.pix_data = need_data ? mem[cap_pix] : r[CH*24-1:0];
  endtask

  // Full frame from a start pulse; optional second start at cycle restart_at
  task automatic run_frame(input string tag, input int restart_at, input bit pin_pattern);
    int b0, f0, k, first_rise, first_a1;
    logic [5:0] w0, w1;
    b0 = busy_total;
    f0 = fd_total;
    first_rise = -1;
    first_a1   = -1;
    w0 = '0;
    w1 = '0;
    bus.start = 1'b1;
    k = cyc + 1;
    tick();
    bus.start = 1'b0;
    for (int n = 0; n < 2000 && fd_total == f0; n++) begin
      tick();
      bus.start = (cyc - k == restart_at - 1) ? 1'b1 : 1'b0;
      if (first_rise < 0 && bus.o_out != '0) first_rise = cyc;
      if (first_a1 < 0 && bus.pix_addr == 1'b1) first_a1 = cyc;
      if (cyc - k >= 2 && cyc - k < 8) begin
        w0 = {w0[4:0], bus.o_out[0]};
        w1 = {w1[4:0], bus.o_out[1]};
      end
    end
    bus.start = 1'b0;
    chk({tag, "_busy_len"}, busy_total - b0, 300);
    chk({tag, "_done_count"}, fd_total - f0, 1);
    chk({tag, "_first_rise"}, first_rise - k, 2);
    chk({tag, "_prefetch_cycle"}, first_a1 - k, 140);
    if (pin_pattern) begin
      chk({tag, "_ch0_bit0"}, int'(w0), 6'b111100);
      chk({tag, "_ch1_bit0"}, int'(w1), 6'b110000);
    end
    $display("[TB] frame %s: busy=%0d done=%0d", tag, busy_total - b0, fd_total - f0);
    tick();
    tick();
  endtask

  initial begin
    int c0, f0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.pix_data = '0;
    mem[0] = {24'h000000, 24'hFFFFFF};
    mem[1] = {24'hA5A5A5, 24'h0F0F0F};
    repeat (3) tick();
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_o_out", int'(bus.o_out), 0);
    chk("reset_addr", int'(bus.pix_addr), 0);
    chk("reset_done", int'(bus.frame_done), 0);
    c0 = cyc;
    reset = 1'b0;
`ifdef WS2812_AUTO_REFRESH_EN
    begin
      int first_rise;
      first_rise = -1;
      for (int n = 0; n < 1500 && fd_total < 3; n++) begin
        tick();
        if (first_rise < 0 && bus.o_out != '0) first_rise = cyc;
      end
      chk("auto_first_rise", first_rise - c0, 3);
      chk("auto_done_count", fd_total, 3);
      chk("auto_done_gap", fd_gap, 301);
      chk("auto_first_done", last_fd_cyc - 2 * 301 - c0, 301);
      $display("[TB] auto refresh: frames=%0d gap=%0d", fd_total, fd_gap);
    end
`else
    tick();
    run_frame("single", -1, 1'b1);
    run_frame("start_in_busy", 50, 1'b0);
    for (int i = 0; i < 3; i++) begin
      for (int p = 0; p < PX; p++) mem[p] = {24'($urandom()), 24'($urandom())};
      run_frame("random", -1, 1'b0);
    end

    // reset mid-frame
    f0 = fd_total;
    bus.start = 1'b1;
    c0 = cyc + 1;
    tick();
    bus.start = 1'b0;
    while (cyc - c0 < 99) tick();
    reset = 1'b1;
    tick();
    chk("midreset_busy", int'(bus.busy), 0);
    chk("midreset_o_out", int'(bus.o_out), 0);
    chk("midreset_addr", int'(bus.pix_addr), 0);
    reset = 1'b0;
    repeat (20) tick();
    chk("midreset_no_done", fd_total - f0, 0);
    $display("[TB] reset mid-frame at cycle %0d", cyc - c0);
    for (int p = 0; p < PX; p++) mem[p] = {24'($urandom()), 24'($urandom())};
    run_frame("after_reset", -1, 1'b0);

    // back-to-back with start held high
    f0 = fd_total;
    bus.start = 1'b1;
    for (int n = 0; n < 1500 && fd_total - f0 < 3; n++) tick();
    bus.start = 1'b0;
    chk("b2b_done_count", fd_total - f0, 3);
    chk("b2b_done_gap", fd_gap, 301);
    $display("[TB] back-to-back: frames=%0d gap=%0d", fd_total - f0, fd_gap);
    for (int n = 0; n < 400 && bus.busy === 1'b1; n++) tick();
    repeat (3) tick();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
